lsu_split_access: RTL and testbench

//  Load/store unit between the core datapath and the data bus. It replaces combinational byte-enable logic

---
 rtl/lsu_split_access.sv | 238 +++++++++++++++++++++++
 tb/tb_lsu_split_access.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_split_access.sv
`default_nettype none
// ============================================================================
// Module      : lsu_split_access
// Description : Registered, handshaked load/store engine. Each core access is
//               issued as one or two aligned bus beats and loads are merged.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_split_access #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int ALLOW_MISALIGNED = 1,
    parameter int TIMEOUT          = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                busValid,
    input  logic                busReady,
    output logic                busWe,
    output logic [ADDR_W-1:0]   busAddr,
    output logic [DATA_W-1:0]   busWData,
    output logic [DATA_W/8-1:0] Byte_Enable,
    input  logic [DATA_W-1:0]   busRData
);

    localparam int c_bytes  = DATA_W / 8;
    localparam int c_offs_w = $clog2(c_bytes);
    localparam int c_cnt_w  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                r_state, w_state_n;
    logic                  r_we, w_we_n;
    logic [2:0]            r_funct3, w_funct3_n;
    logic [c_offs_w-1:0]   r_off, w_off_n;
    logic                  r_cross, w_cross_n;
    logic [c_bytes-1:0]    r_be_hi, w_be_hi_n;
    logic [DATA_W-1:0]     r_wd_hi, w_wd_hi_n;
    logic [DATA_W-1:0]     r_lo, w_lo_n;
    logic [c_cnt_w-1:0]    r_cnt, w_cnt_n;
    logic                  r_bus_valid, w_bus_valid_n;
    logic                  r_bus_we, w_bus_we_n;
    logic [ADDR_W-1:0]     r_bus_addr, w_bus_addr_n;
    logic [DATA_W-1:0]     r_bus_wdata, w_bus_wdata_n;
    logic [c_bytes-1:0]    r_bus_be, w_bus_be_n;
    logic                  r_resp_valid, w_resp_valid_n;
    logic                  r_resp_err, w_resp_err_n;
    logic [DATA_W-1:0]     r_resp_rdata, w_resp_rdata_n;

    // Request decode: lane masks and shifted store data for both beats
    logic [3:0]            w_size;
    logic [c_offs_w-1:0]   w_off;
    logic                  w_cross;
    logic                  w_legal;
    logic [2*c_bytes-1:0]  w_mask;
    logic [2*c_bytes-1:0]  w_be_sh;
    logic [2*DATA_W-1:0]   w_wd_sh;

    always_comb begin
        w_size  = 4'd1 << req_funct3[1:0];
        w_off   = req_addr[c_offs_w-1:0];
        w_cross = (int'(w_off) + int'(w_size)) > c_bytes;
        for (int i = 0; i < 2 * c_bytes; i++) begin
            w_mask[i] = (i < int'(w_size));
        end
        w_be_sh = w_mask << w_off;
        w_wd_sh = {{DATA_W{1'b0}}, req_wdata} << {w_off, 3'b000};
        case (req_funct3)
            3'd0, 3'd1, 3'd2: w_legal = 1'b1;
            3'd3:             w_legal = (DATA_W == 64);
            3'd4, 3'd5:       w_legal = !req_we;
            3'd6:             w_legal = !req_we && (DATA_W == 64);
            default:          w_legal = 1'b0;
        endcase
    end

    // Load merge; the live beat's read data is folded in on its completing edge
    logic [DATA_W-1:0]     w_lo;
    logic [DATA_W-1:0]     w_hi;
    logic [DATA_W-1:0]     w_raw;
    logic [DATA_W-1:0]     w_keep;
    logic                  w_sign;
    logic [DATA_W-1:0]     w_ext;
    logic                  w_timeout;

    always_comb begin
        w_lo  = (r_state == ST_BEAT0) ? busRData : r_lo;
        w_hi  = (r_state == ST_BEAT1) ? busRData : '0;
        w_raw = DATA_W'({w_hi, w_lo} >> {r_off, 3'b000});
        for (int i = 0; i < DATA_W; i++) begin
            w_keep[i] = (i < 8 * (1 << r_funct3[1:0]));
        end
        case (r_funct3[1:0])
            2'd0:    w_sign = w_raw[7];
            2'd1:    w_sign = w_raw[15];
            2'd2:    w_sign = w_raw[31];
            default: w_sign = w_raw[DATA_W-1];
        endcase
        w_ext     = (w_raw & w_keep) | ((w_sign && !r_funct3[2]) ? ~w_keep : '0);
        w_timeout = (TIMEOUT > 0) && !busReady && (r_cnt == c_cnt_last);
    end

    always_comb begin
        w_state_n      = r_state;
        w_we_n         = r_we;
        w_funct3_n     = r_funct3;
        w_off_n        = r_off;
        w_cross_n      = r_cross;
        w_be_hi_n      = r_be_hi;
        w_wd_hi_n      = r_wd_hi;
        w_lo_n         = r_lo;
        w_cnt_n        = r_cnt;
        w_bus_valid_n  = r_bus_valid;
        w_bus_we_n     = r_bus_we;
        w_bus_addr_n   = r_bus_addr;
        w_bus_wdata_n  = r_bus_wdata;
        w_bus_be_n     = r_bus_be;
        w_resp_valid_n = 1'b0;
        w_resp_err_n   = 1'b0;
        w_resp_rdata_n = '0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_we_n     = req_we;
                    w_funct3_n = req_funct3;
                    w_off_n    = w_off;
                    w_cross_n  = w_cross;
                    w_be_hi_n  = w_be_sh[2*c_bytes-1:c_bytes];
                    w_wd_hi_n  = w_wd_sh[2*DATA_W-1:DATA_W];
                    if (!w_legal || (w_cross && (ALLOW_MISALIGNED == 0))) begin
                        w_state_n      = ST_RESP;
                        w_resp_valid_n = 1'b1;
                        w_resp_err_n   = 1'b1;
                    end else begin
                        w_state_n     = ST_BEAT0;
                        w_cnt_n       = '0;
                        w_bus_valid_n = 1'b1;
                        w_bus_we_n    = req_we;
                        w_bus_addr_n  = {req_addr[ADDR_W-1:c_offs_w], {c_offs_w{1'b0}}};
                        w_bus_be_n    = w_be_sh[c_bytes-1:0];
                        w_bus_wdata_n = w_wd_sh[DATA_W-1:0];
                    end
                end
            end
            ST_BEAT0, ST_BEAT1: begin
                if (busReady && (r_state == ST_BEAT0) && r_cross) begin
                    w_state_n     = ST_BEAT1;
                    w_lo_n        = busRData;
                    w_cnt_n       = '0;
                    w_bus_addr_n  = r_bus_addr + ADDR_W'(c_bytes);
                    w_bus_be_n    = r_be_hi;
                    w_bus_wdata_n = r_wd_hi;
                end else if (busReady || w_timeout) begin
                    w_state_n      = ST_RESP;
                    w_bus_valid_n  = 1'b0;
                    w_bus_we_n     = 1'b0;
                    w_bus_addr_n   = '0;
                    w_bus_be_n     = '0;
                    w_bus_wdata_n  = '0;
                    w_resp_valid_n = 1'b1;
                    w_resp_err_n   = !busReady;
                    w_resp_rdata_n = (busReady && !r_we) ? w_ext : '0;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_funct3     <= '0;
            r_off        <= '0;
            r_cross      <= 1'b0;
            r_be_hi      <= '0;
            r_wd_hi      <= '0;
            r_lo         <= '0;
            r_cnt        <= '0;
            r_bus_valid  <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_be     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_n;
            r_we         <= w_we_n;
            r_funct3     <= w_funct3_n;
            r_off        <= w_off_n;
            r_cross      <= w_cross_n;
            r_be_hi      <= w_be_hi_n;
            r_wd_hi      <= w_wd_hi_n;
            r_lo         <= w_lo_n;
            r_cnt        <= w_cnt_n;
            r_bus_valid  <= w_bus_valid_n;
            r_bus_we     <= w_bus_we_n;
            r_bus_addr   <= w_bus_addr_n;
            r_bus_wdata  <= w_bus_wdata_n;
            r_bus_be     <= w_bus_be_n;
            r_resp_valid <= w_resp_valid_n;
            r_resp_err   <= w_resp_err_n;
            r_resp_rdata <= w_resp_rdata_n;
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign resp_rdata  = r_resp_rdata;
    assign busValid    = r_bus_valid;
    assign busWe       = r_bus_we;
    assign busAddr     = r_bus_addr;
    assign busWData    = r_bus_wdata;
    assign Byte_Enable = r_bus_be;

endmodule
`default_nettype wire

// File: tb/tb_lsu_split_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_split_access
// Description : Directed self-checking bench for lsu_split_access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_split_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid_b;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        busReady;
    logic [31:0] busRData;

    logic        req_ready, resp_valid, resp_err, busValid, busWe;
    logic [31:0] resp_rdata, busAddr, busWData;
    logic [3:0]  Byte_Enable;
    logic        req_ready_b, resp_valid_b, resp_err_b, busValid_b, busWe_b;
    logic [31:0] resp_rdata_b, busAddr_b, busWData_b;
    logic [3:0]  Byte_Enable_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_split_access #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busValid(busValid), .busReady(busReady), .busWe(busWe), .busAddr(busAddr),
        .busWData(busWData), .Byte_Enable(Byte_Enable), .busRData(busRData)
    );

    lsu_split_access #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(0), .TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
        .busValid(busValid_b), .busReady(busReady), .busWe(busWe_b), .busAddr(busAddr_b),
        .busWData(busWData_b), .Byte_Enable(Byte_Enable_b), .busRData(busRData)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge; afterwards the bench sits in cycle N+1
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic to_b);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        if (to_b) req_valid_b = 1'b1;
        else      req_valid   = 1'b1;
        tick();
        req_valid   = 1'b0;
        req_valid_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_valid_b = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
        busReady = 1'b1; busRData = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        chk("rst_ready",   req_ready, 1);
        chk("rst_bvalid",  busValid, 0);
        chk("rst_rvalid",  resp_valid, 0);
        chk("rst_err",     resp_err, 0);
        chk("rst_busaddr", busAddr, 0);
        chk("rst_be",      Byte_Enable, 0);
        chk("rst_wdata",   busWData, 0);
        chk("rst_rdata",   resp_rdata, 0);
        chk("rst_b_ready", req_ready_b, 1);

        // lw aligned
        busRData = 32'hDEADBEEF;
        issue(1'b0, 3'd2, 32'h100, 32'h0, 1'b0);
        chk("lw_bvalid", busValid, 1);
        chk("lw_addr",   busAddr, 32'h100);
        chk("lw_be",     Byte_Enable, 4'hF);
        chk("lw_we",     busWe, 0);
        chk("lw_busy",   req_ready, 0);
        chk("lw_early",  resp_valid, 0);
        tick();
        chk("lw_rvalid", resp_valid, 1);
        chk("lw_rdata",  resp_rdata, 32'hDEADBEEF);
        chk("lw_err",    resp_err, 0);
        chk("lw_bdrop",  busValid, 0);
        tick();
        chk("lw_pulse",  resp_valid, 0);
        chk("lw_idle",   req_ready, 1);

        // lb / lbu at lane 3
        busRData = 32'h80FF_FF00;
        issue(1'b0, 3'd0, 32'h103, 32'h0, 1'b0);
        chk("lb_addr", busAddr, 32'h100);
        chk("lb_be",   Byte_Enable, 4'b1000);
        tick();
        chk("lb_rdata", resp_rdata, 32'hFFFFFF80);
        tick();
        issue(1'b0, 3'd4, 32'h103, 32'h0, 1'b0);
        tick();
        chk("lbu_rdata", resp_rdata, 32'h00000080);
        tick();

        // lh at offset 1 sign-extends 0xFFFF
        busRData = 32'h00FF_FF00;
        issue(1'b0, 3'd1, 32'h101, 32'h0, 1'b0);
        chk("lh_be", Byte_Enable, 4'b0110);
        tick();
        chk("lh_rdata", resp_rdata, 32'hFFFFFFFF);
        tick();

        // sb: single-lane store data placement
        issue(1'b1, 3'd0, 32'h201, 32'h0000_005A, 1'b0);
        chk("sb_we",    busWe, 1);
        chk("sb_be",    Byte_Enable, 4'b0010);
        chk("sb_wdata", busWData, 32'h0000_5A00);
        tick();
        chk("sb_rvalid", resp_valid, 1);
        tick();

        // split sw
        issue(1'b1, 3'd2, 32'h102, 32'hAABBCCDD, 1'b0);
        chk("sw0_addr",  busAddr, 32'h100);
        chk("sw0_be",    Byte_Enable, 4'b1100);
        chk("sw0_wdata", busWData, 32'hCCDD0000);
        chk("sw0_we",    busWe, 1);
        tick();
        chk("sw1_valid", busValid, 1);
        chk("sw1_addr",  busAddr, 32'h104);
        chk("sw1_be",    Byte_Enable, 4'b0011);
        chk("sw1_wdata", busWData, 32'h0000AABB);
        chk("sw1_early", resp_valid, 0);
        tick();
        chk("sw_rvalid", resp_valid, 1);
        chk("sw_rdata",  resp_rdata, 0);
        chk("sw_err",    resp_err, 0);
        tick();

        // split lh across the top of the address space
        busRData = 32'h12345678;
        issue(1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0, 1'b0);
        chk("lhw0_addr", busAddr, 32'hFFFFFFFC);
        chk("lhw0_be",   Byte_Enable, 4'b1000);
        tick();
        busRData = 32'hABCDEF34;
        chk("lhw1_addr", busAddr, 32'h0);
        chk("lhw1_be",   Byte_Enable, 4'b0001);
        tick();
        chk("lhw_rvalid", resp_valid, 1);
        chk("lhw_rdata",  resp_rdata, 32'h00003412);
        tick();

        // two wait states before busReady
        busReady = 1'b0;
        issue(1'b0, 3'd2, 32'h200, 32'h0, 1'b0);
        tick();
        chk("ws_hold_valid", busValid, 1);
        chk("ws_hold_addr",  busAddr, 32'h200);
        tick();
        chk("ws_no_resp", resp_valid, 0);
        busReady = 1'b1;
        busRData = 32'h01234567;
        tick();
        chk("ws_rvalid", resp_valid, 1);
        chk("ws_rdata",  resp_rdata, 32'h01234567);
        chk("ws_err",    resp_err, 0);
        tick();

        // timeout after four unanswered cycles
        busReady = 1'b0;
        issue(1'b0, 3'd2, 32'h300, 32'h0, 1'b0);
        tick(); tick(); tick();
        chk("to_still_valid", busValid, 1);
        chk("to_no_resp",     resp_valid, 0);
        tick();
        chk("to_bdrop",  busValid, 0);
        chk("to_rvalid", resp_valid, 1);
        chk("to_err",    resp_err, 1);
        chk("to_rdata",  resp_rdata, 0);
        tick();

        // reset during a BEAT0 wait
        issue(1'b0, 3'd2, 32'h400, 32'h0, 1'b0);
        chk("ra_valid", busValid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ra_bdrop",  busValid, 0);
        chk("ra_ready",  req_ready, 1);
        chk("ra_nresp",  resp_valid, 0);
        tick();
        chk("ra_nresp2", resp_valid, 0);
        busReady = 1'b1;

        // req_valid held while busy: exactly one transaction
        busRData = 32'hCAFEF00D;
        req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h500; req_valid = 1'b1;
        tick();
        chk("hold_beat", busValid, 1);
        tick();
        chk("hold_resp", resp_valid, 1);
        chk("hold_data", resp_rdata, 32'hCAFEF00D);
        tick();
        req_valid = 1'b0;
        chk("hold_nobus", busValid, 0);
        tick();
        chk("hold_nobus2", busValid, 0);
        chk("hold_noresp", resp_valid, 0);

        // illegal funct3 on the 32-bit unit
        issue(1'b0, 3'd3, 32'h600, 32'h0, 1'b0);
        chk("ld_nobus", busValid, 0);
        chk("ld_err",   resp_err, 1);
        chk("ld_rv",    resp_valid, 1);
        tick();
        issue(1'b1, 3'd4, 32'h600, 32'h0, 1'b0);
        chk("sbu_err", resp_err, 1);
        tick();

        // misaligned rejection on the strict instance
        issue(1'b0, 3'd2, 32'h101, 32'h0, 1'b1);
        chk("ma_nobus", busValid_b, 0);
        chk("ma_rv",    resp_valid_b, 1);
        chk("ma_err",   resp_err_b, 1);
        chk("ma_rdata", resp_rdata_b, 0);
        tick();
        busRData = 32'h55AA55AA;
        issue(1'b0, 3'd2, 32'h104, 32'h0, 1'b1);
        chk("al_bus", busValid_b, 1);
        tick();
        chk("al_rdata", resp_rdata_b, 32'h55AA55AA);
        chk("al_err",   resp_err_b, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
